// File: rtl/lamp_pkg.sv
// Shared mode encoding, step width and priority ranking for the lamp controller.
package lamp_pkg;

  localparam int unsigned STEP_W = 2;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_IDLE   = 3'd0;
  localparam mode_t MODE_RIGHT  = 3'd1;
  localparam mode_t MODE_LEFT   = 3'd2;
  localparam mode_t MODE_HAZARD = 3'd3;
  localparam mode_t MODE_BRAKE  = 3'd4;
  localparam mode_t MODE_DOOR   = 3'd5;

  // Rank is kept separate from the encoding so either can change independently.
  function automatic logic [2:0] prio(input mode_t m);
    case (m)
      MODE_IDLE:   return 3'd0;
      MODE_RIGHT:  return 3'd1;
      MODE_LEFT:   return 3'd2;
      MODE_HAZARD: return 3'd3;
      MODE_BRAKE:  return 3'd4;
      MODE_DOOR:   return 3'd5;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/req_sync.sv
// Multi-flop synchroniser for one asynchronous level input.
module req_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lamp_mode_arbiter.sv
// Resolves synchronised lamp requests into one mode with a minimum dwell, and
// produces the animation tick and step index for the lamp datapath.
module lamp_mode_arbiter
  import lamp_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned HOLD_TICKS  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqL,
  input  logic              reqR,
  input  logic              reqBrake,
  input  logic              reqDoor,
  output logic [2:0]        mode,
  output logic [STEP_W-1:0] step,
  output logic              tick,
  output logic              modeChg
);

  localparam int unsigned PrescW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(HOLD_TICKS);

  logic l_s, r_s, brake_s, door_s;

  req_sync #(.STAGES(SYNC_STAGES)) u_sync_l (
    .clk_i(clk), .rst_ni(rst), .d_i(reqL), .q_o(l_s)
  );
  req_sync #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk_i(clk), .rst_ni(rst), .d_i(reqR), .q_o(r_s)
  );
  req_sync #(.STAGES(SYNC_STAGES)) u_sync_brake (
    .clk_i(clk), .rst_ni(rst), .d_i(reqBrake), .q_o(brake_s)
  );
  req_sync #(.STAGES(SYNC_STAGES)) u_sync_door (
    .clk_i(clk), .rst_ni(rst), .d_i(reqDoor), .q_o(door_s)
  );

  mode_t              mode_q, mode_d, winner;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               tick_q, tick_d;
  logic               chg_q, chg_d;
  logic               change;

  always_comb begin
    winner = MODE_IDLE;
    if (door_s) begin
      winner = MODE_DOOR;
    end else if (brake_s) begin
      winner = MODE_BRAKE;
    end else if (l_s && r_s) begin
      winner = MODE_HAZARD;
    end else if (l_s) begin
      winner = MODE_LEFT;
    end else if (r_s) begin
      winner = MODE_RIGHT;
    end
  end

  assign change = (winner != mode_q) &&
                  ((prio(winner) > prio(mode_q)) || (hold_q == HoldMax));

  // A mode change restarts the animation and overrides any coincident tick.
  always_comb begin
    mode_d  = mode_q;
    step_d  = step_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    tick_d  = 1'b0;
    chg_d   = 1'b0;
    if (change) begin
      mode_d  = winner;
      step_d  = '0;
      presc_d = '0;
      hold_d  = '0;
      chg_d   = 1'b1;
    end else begin
      presc_d = (presc_q == PrescLast) ? '0 : presc_q + PrescW'(1);
      tick_d  = (presc_d == PrescLast);
      if (tick_q) begin
        if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
        case (mode_q)
          MODE_LEFT, MODE_RIGHT, MODE_HAZARD: step_d = step_q + STEP_W'(1);
          MODE_DOOR:                          step_d = {1'b0, ~step_q[0]};
          default:                            step_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_IDLE;
      step_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      tick_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
      chg_q   <= chg_d;
    end
  end

  assign mode    = mode_q;
  assign step    = step_q;
  assign tick    = tick_q;
  assign modeChg = chg_q;

endmodule
